// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between an instruction-fetch
// requester and a data requester. Data normally wins; fetch is forced through
// after losing STARVE_LIMIT consecutive cycles. Memory read latency is one
// cycle, and responses are routed back to whichever side owned the grant.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   i_req/i_addr      fetch request and byte address
//   i_gnt             fetch granted this cycle (combinational)
//   i_rvalid/i_rdata  fetch response, one cycle after grant
//   d_req/d_we/d_wstrb/d_addr/d_wdata   data request
//   d_gnt             data granted this cycle (combinational)
//   d_rvalid/d_rdata  data response (load data, or zero for a write ack)
//   m_en/m_we/m_wstrb/m_addr/m_wdata   memory command (combinational)
//   m_rdata           memory read data, valid one cycle after m_en
module mem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned AW           = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_req,
   input  logic [31:0]   i_addr,
   output logic          i_gnt,
   output logic          i_rvalid,
   output logic [31:0]   i_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [3:0]    d_wstrb,
   input  logic [31:0]   d_addr,
   input  logic [31:0]   d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [31:0]   d_rdata,
   output logic          m_en,
   output logic          m_we,
   output logic [3:0]    m_wstrb,
   output logic [AW-1:0] m_addr,
   output logic [31:0]   m_wdata,
   input  logic [31:0]   m_rdata
);

   localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_FETCH = 2'd1,
      OWN_DATA  = 2'd2
   } owner_e;

   owner_e          owner_q, owner_d;
   logic            was_write_q, was_write_d;
   logic [SW-1:0]   starve_cnt_q, starve_cnt_d;
   logic            fetch_win;

   // Byte-offset and upper address bits are intentionally ignored.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{i_addr[31:AW+2], i_addr[1:0], d_addr[31:AW+2], d_addr[1:0]};

   // State registers: response owner, write flag, fetch starvation counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner_q      <= OWN_NONE;
         was_write_q  <= 1'b0;
         starve_cnt_q <= '0;
      end else begin
         owner_q      <= owner_d;
         was_write_q  <= was_write_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   // Arbitration, memory command and next-state. Everything is held idle
   // while reset is asserted so no request leaks through.
   always_comb begin
      fetch_win    = 1'b0;
      i_gnt        = 1'b0;
      d_gnt        = 1'b0;
      m_en         = 1'b0;
      m_we         = 1'b0;
      m_wstrb      = 4'b0000;
      m_addr       = '0;
      m_wdata      = d_wdata;
      owner_d      = OWN_NONE;
      was_write_d  = 1'b0;
      starve_cnt_d = '0;
      if (rst) begin
         // Fetch wins when alone, or when it has starved for the full limit.
         fetch_win = i_req && (!d_req || (starve_cnt_q == SW'(STARVE_LIMIT)));
         if (fetch_win) begin
            i_gnt   = 1'b1;
            m_en    = 1'b1;
            m_addr  = i_addr[AW+1:2];
            owner_d = OWN_FETCH;
         end else if (d_req) begin
            d_gnt       = 1'b1;
            m_en        = 1'b1;
            m_we        = d_we;
            m_wstrb     = d_wstrb;
            m_addr      = d_addr[AW+1:2];
            owner_d     = OWN_DATA;
            was_write_d = d_we;
         end
         // Count lost cycles while fetch keeps requesting; saturate.
         if (i_req && !fetch_win) begin
            starve_cnt_d = (starve_cnt_q == SW'(STARVE_LIMIT)) ? starve_cnt_q
                                                               : starve_cnt_q + SW'(1);
         end
      end
   end

   // Response routing: the owner of last cycle's grant sees m_rdata.
   always_comb begin
      i_rvalid = rst && (owner_q == OWN_FETCH);
      d_rvalid = rst && (owner_q == OWN_DATA);
      i_rdata  = i_rvalid ? m_rdata : 32'h0;
      d_rdata  = (d_rvalid && !was_write_q) ? m_rdata : 32'h0;
   end

endmodule
